// File: rtl/mux_sel_scanner.sv
// Channel scanner for the 4:1 mux: steps SEL through the enabled channels, dwells DWELL
// cycles on each and emits the fed-back mux output tagged with its channel.
module mux_sel_scanner #(
    parameter int unsigned DWELL  = 4,
    parameter int unsigned DATA_W = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              MODE,
    input  logic [3:0]        EN_MASK,
    input  logic [DATA_W-1:0] X_IN,
    output logic [1:0]        SEL,
    output logic              SAMPLE_VALID,
    output logic [DATA_W-1:0] SAMPLE_DATA,
    output logic [1:0]        SAMPLE_CH,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        mask_q, mask_d;
    logic              mode_q, mode_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        ch_q, ch_d;
    logic              done_q, done_d;

    function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) lowest_ch = 2'(i);
        end
    endfunction

    // Smallest positive offset wins; a single-channel mask falls back to cur.
    function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] c;
        next_ch = cur;
        for (int i = 3; i >= 1; i--) begin
            c = cur + 2'(i);
            if (mask[c]) next_ch = c;
        end
    endfunction

    function automatic logic is_highest(input logic [1:0] cur, input logic [3:0] mask);
        is_highest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && (i > int'(cur))) is_highest = 1'b0;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        valid_d = 1'b0;
        data_d  = data_q;
        ch_d    = ch_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START && !STOP && (EN_MASK != 4'd0)) begin
                    state_d = StScan;
                    mask_d  = EN_MASK;
                    mode_d  = MODE;
                    sel_d   = lowest_ch(EN_MASK);
                    cnt_d   = 8'd0;
                end
            end
            StScan: begin
                if (STOP) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'(DWELL - 1)) begin
                    valid_d = 1'b1;
                    data_d  = X_IN;
                    ch_d    = sel_q;
                    cnt_d   = 8'd0;
                    if (!mode_q && is_highest(sel_q, mask_q)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        sel_d = next_ch(sel_q, mask_q);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            sel_q   <= 2'd0;
            mask_q  <= 4'd0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    assign SEL          = sel_q;
    assign SAMPLE_VALID = valid_q;
    assign SAMPLE_DATA  = data_q;
    assign SAMPLE_CH    = ch_q;
    assign BUSY         = (state_q == StScan);
    assign DONE         = done_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Bench for mux_sel_scanner: channel-list reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_mux_sel_scanner;

    localparam int unsigned DWELL  = 4;
    localparam int unsigned DATA_W = 2;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              START = 1'b0;
    logic              STOP = 1'b0;
    logic              MODE = 1'b0;
    logic [3:0]        EN_MASK = 4'd0;
    logic [DATA_W-1:0] X_IN;
    logic [1:0]        SEL;
    logic              SAMPLE_VALID;
    logic [DATA_W-1:0] SAMPLE_DATA;
    logic [1:0]        SAMPLE_CH;
    logic              BUSY;
    logic              DONE;

    logic [DATA_W-1:0] mux_tbl [4];
    initial begin
        mux_tbl[0] = 2'b00;
        mux_tbl[1] = 2'b01;
        mux_tbl[2] = 2'b01;
        mux_tbl[3] = 2'b11;
    end
    assign X_IN = mux_tbl[SEL];

    mux_sel_scanner #(.DWELL(DWELL), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .MODE(MODE),
        .EN_MASK(EN_MASK), .X_IN(X_IN), .SEL(SEL), .SAMPLE_VALID(SAMPLE_VALID),
        .SAMPLE_DATA(SAMPLE_DATA), .SAMPLE_CH(SAMPLE_CH), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int n_valid = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of enabled channels walked by index, ticks since last sample.
    bit         m_active = 1'b0;
    bit         m_mode = 1'b0;
    int         m_ticks = 0;
    int         m_idx = 0;
    int         m_n = 0;
    int         m_chans [4];
    logic [1:0] e_sel = 2'd0;
    logic       e_valid = 1'b0;
    logic [1:0] e_data = 2'd0;
    logic [1:0] e_ch = 2'd0;
    logic       e_done = 1'b0;

    always @(posedge CLK) begin
        e_valid = 1'b0;
        e_done  = 1'b0;
        if (!RST_N) begin
            m_active = 1'b0;
            e_sel = 2'd0;
            e_data = 2'd0;
            e_ch = 2'd0;
        end else if (!m_active) begin
            if (START && !STOP && EN_MASK != 4'd0) begin
                m_n = 0;
                for (int c = 0; c < 4; c++) begin
                    if (EN_MASK[c]) begin
                        m_chans[m_n] = c;
                        m_n++;
                    end
                end
                m_idx = 0;
                m_mode = MODE;
                m_ticks = 0;
                m_active = 1'b1;
                e_sel = 2'(m_chans[0]);
            end
        end else if (STOP) begin
            m_active = 1'b0;
        end else begin
            m_ticks++;
            if (m_ticks == int'(DWELL)) begin
                m_ticks = 0;
                e_valid = 1'b1;
                e_ch = e_sel;
                e_data = mux_tbl[e_sel];
                if (m_idx == m_n - 1 && !m_mode) begin
                    e_done = 1'b1;
                    m_active = 1'b0;
                end else begin
                    m_idx = (m_idx + 1) % m_n;
                    e_sel = 2'(m_chans[m_idx]);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("sel", 32'(SEL), 32'(e_sel));
            check("valid", 32'(SAMPLE_VALID), 32'(e_valid));
            check("data", 32'(SAMPLE_DATA), 32'(e_data));
            check("ch", 32'(SAMPLE_CH), 32'(e_ch));
            check("busy", 32'(BUSY), 32'(m_active));
            check("done", 32'(DONE), 32'(e_done));
            if (SAMPLE_VALID === 1'b1) n_valid++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Raise START before the edge, drop it after: returns just past edge 0.
    task automatic launch(input logic [3:0] mask, input logic mode);
        EN_MASK = mask;
        MODE = mode;
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic expect_sample(input string name, input logic [1:0] ch, input logic [1:0] data,
                                 input logic done);
        check({name, "_valid"}, 32'(SAMPLE_VALID), 32'd1);
        check({name, "_ch"}, 32'(SAMPLE_CH), 32'(ch));
        check({name, "_data"}, 32'(SAMPLE_DATA), 32'(data));
        check({name, "_done"}, 32'(DONE), 32'(done));
    endtask

    int v0;

    initial begin
        // Reset held with START and full mask.
        START = 1'b1;
        EN_MASK = 4'b1111;
        tick(1);
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", 32'(BUSY), 32'd0);
            check("rst_sel", 32'(SEL), 32'd0);
            tick(1);
        end
        START = 1'b0;
        RST_N = 1'b1;
        tick(3);
        check("post_rst_busy", 32'(BUSY), 32'd0);

        // Single pass, full mask.
        launch(4'b1111, 1'b0);
        check("sp_sel0", 32'(SEL), 32'd0);
        check("sp_busy", 32'(BUSY), 32'd1);
        tick(4);
        expect_sample("sp_s0", 2'd0, 2'b00, 1'b0);
        check("sp_sel1", 32'(SEL), 32'd1);
        tick(4);
        expect_sample("sp_s1", 2'd1, 2'b01, 1'b0);
        check("sp_sel2", 32'(SEL), 32'd2);
        tick(4);
        expect_sample("sp_s2", 2'd2, 2'b01, 1'b0);
        check("sp_sel3", 32'(SEL), 32'd3);
        tick(4);
        expect_sample("sp_s3", 2'd3, 2'b11, 1'b1);
        check("sp_idle", 32'(BUSY), 32'd0);
        check("sp_sel_hold", 32'(SEL), 32'd3);
        tick(3);

        // Sparse mask.
        launch(4'b1010, 1'b0);
        check("sm_sel0", 32'(SEL), 32'd1);
        tick(4);
        expect_sample("sm_s0", 2'd1, 2'b01, 1'b0);
        check("sm_sel1", 32'(SEL), 32'd3);
        tick(4);
        expect_sample("sm_s1", 2'd3, 2'b11, 1'b1);
        check("sm_idle", 32'(BUSY), 32'd0);
        tick(2);

        // Continuous with wrap, then STOP at edge 10.
        launch(4'b1001, 1'b1);
        tick(4);
        expect_sample("cw_s0", 2'd0, 2'b00, 1'b0);
        tick(4);
        expect_sample("cw_s1", 2'd3, 2'b11, 1'b0);
        check("cw_wrap", 32'(SEL), 32'd0);
        tick(1);
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        check("cw_stop_busy", 32'(BUSY), 32'd0);
        v0 = n_valid;
        tick(8);
        check("cw_no_more", 32'(n_valid - v0), 32'd0);

        // Mid-scan reset at edge 6, then fresh start.
        launch(4'b1111, 1'b0);
        tick(5);
        RST_N = 1'b0;
        tick(1);
        RST_N = 1'b1;
        check("mr_sel", 32'(SEL), 32'd0);
        check("mr_busy", 32'(BUSY), 32'd0);
        v0 = n_valid;
        tick(2);
        check("mr_nosample", 32'(n_valid - v0), 32'd0);
        launch(4'b1111, 1'b0);
        check("mr_restart_sel", 32'(SEL), 32'd0);
        tick(4);
        expect_sample("mr_s0", 2'd0, 2'b00, 1'b0);
        tick(13);

        // START with empty mask.
        launch(4'b0000, 1'b0);
        check("em_busy", 32'(BUSY), 32'd0);
        tick(2);

        // START re-pulsed while busy and mask changed mid-scan.
        launch(4'b1111, 1'b0);
        EN_MASK = 4'b0001;
        tick(1);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(2);
        expect_sample("ib_s0", 2'd0, 2'b00, 1'b0);
        tick(8);
        expect_sample("ib_s2", 2'd2, 2'b01, 1'b0);
        tick(4);
        expect_sample("ib_s3", 2'd3, 2'b11, 1'b1);
        tick(2);

        // STOP on the dwell-completion edge.
        launch(4'b1111, 1'b0);
        tick(3);
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        check("sd_valid", 32'(SAMPLE_VALID), 32'd0);
        check("sd_busy", 32'(BUSY), 32'd0);
        check("sd_sel", 32'(SEL), 32'd0);
        tick(3);

        // STOP in IDLE has no effect on a following START.
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        launch(4'b0100, 1'b0);
        check("si_sel", 32'(SEL), 32'd2);
        tick(4);
        expect_sample("si_s0", 2'd2, 2'b01, 1'b1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Upstream sequencer for the 4:1, 2-bit channel multiplexer.
- Drives the mux SEL through the enabled channels in ascending order and holds each channel for a programmable dwell time.
- At the end of each dwell it captures the mux output X (returned on X_IN) and presents it tagged with its channel number.
- Supports single-pass and continuous scanning for the lab datapath.

Parameters:
DWELL, 4, clock cycles SEL is held per channel before sampling; legal range 1..255.
DATA_W, 2, width of mux data (X_IN, SAMPLE_DATA).

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST_N  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
START  input  1  start request, level-sampled each edge.
STOP  input  1  abort request, level-sampled each edge.
MODE  input  1  0 = single pass, 1 = continuous; latched at accepted START.
EN_MASK  input  4  channel enable mask, bit n = channel n; latched at accepted START.
X_IN  input  DATA_W  mux output X fed back.
SEL  output  2  mux select.
SAMPLE_VALID  output  1  one-cycle strobe; SAMPLE_DATA/SAMPLE_CH valid.
SAMPLE_DATA  output  DATA_W  captured X_IN.
SAMPLE_CH  output  2  channel SAMPLE_DATA came from.
BUSY  output  1  scan in progress.
DONE  output  1  one-cycle pulse at end of a single pass.

Behaviour:
Registers and reset:
- All outputs are registered.
- RST_N low at an edge sets: state IDLE, dwell counter 0, SEL=0, SAMPLE_VALID=0, SAMPLE_DATA=0, SAMPLE_CH=0, BUSY=0, DONE=0, latched mask/mode 0.
- Reset overrides every other input and may occur at any point, including mid-scan. No partial sample or DONE is emitted.

States:
- IDLE: BUSY=0.
- SCAN: BUSY=1; dwell counter runs.

IDLE to SCAN:
- Condition: START=1, STOP=0, EN_MASK!=0 at edge E.
- Latch EN_MASK and MODE.
- Set SEL to the lowest enabled channel, clear the counter, set BUSY=1.
- START with EN_MASK=0 is ignored; START with STOP=1 is ignored (STOP has priority).

SCAN dwell and sample:
- The counter increments each edge.
- At edge E+DWELL (counter reaching DWELL) the block captures X_IN. It then drives SAMPLE_VALID=1, SAMPLE_DATA=X_IN, SAMPLE_CH=current SEL for exactly one cycle.
- On that same edge it advances SEL to the next enabled channel (ascending, wrapping 3 to 0) and clears the counter.
- Sample period per channel is exactly DWELL cycles. First sample latency is DWELL cycles after the accepted START.
- A one-channel mask keeps SEL constant and samples it every DWELL cycles.

Pass completion:
- MODE=0: when the highest-index enabled channel is sampled, assert DONE=1 with that SAMPLE_VALID. Return to IDLE with BUSY=0 and leave SEL at the last sampled channel.
- MODE=1: wrap to the lowest enabled channel and continue indefinitely. DONE is never asserted.

STOP:
- STOP=1 in SCAN returns the block to IDLE at that edge with BUSY=0. SEL holds its value and DONE stays 0.
- If STOP coincides with dwell completion, the sample is suppressed (no SAMPLE_VALID).
- STOP in IDLE has no effect.

Ignored while busy:
- START in SCAN is ignored.
- EN_MASK and MODE changes after START are ignored until the next accepted START.

Default strobes: SAMPLE_DATA and SAMPLE_CH hold their last values when SAMPLE_VALID=0.

Test Plan:
- Reset: RST_N=0 with START=1 and EN_MASK=1111 for 3 edges -> every output 0, BUSY never rises. Reset released -> still IDLE until START.
- Single pass, DWELL=4, EN_MASK=1111, MODE=0, mux model A=00 B=01 C=01 D=11, START at edge 0 -> SEL=0,1,2,3 changing at edges 0,4,8,12. SAMPLE_VALID after edges 4,8,12,16 with (CH,DATA)=(0,00),(1,01),(2,01),(3,11). DONE with the 4th sample, BUSY=0 after edge 16.
- Sparse mask: EN_MASK=1010, MODE=0 -> SEL=1 then 3, samples (1,01),(3,11) after edges 4 and 8. DONE after edge 8, channels 0 and 2 never selected.
- Continuous wrap plus STOP: EN_MASK=1001, MODE=1 -> samples alternate CH 0,3,0,... with DATA 00,11,00. STOP=1 at edge 10 -> BUSY=0 after edge 10, no further SAMPLE_VALID, DONE never 1.
- Mid-scan reset: EN_MASK=1111 single pass, RST_N=0 at edge 6 -> after edge 6 all outputs 0, no sample after edge 8. A fresh START restarts from channel 0.
- Corners:
  - START with EN_MASK=0000 -> no BUSY.
  - START pulsed while BUSY -> ignored, sample timing unchanged.
  - STOP at the dwell-completion edge (edge 4) -> no SAMPLE_VALID, BUSY=0.
  - EN_MASK changed mid-scan -> ignored.
